// File: rtl/lcd_mon_pkg.sv
// Shared constants, FSM state and command classification for the LCD bus monitor.
package lcd_mon_pkg;

  localparam logic [7:0] CLR        = 8'h01;
  localparam logic [7:0] HOME_MASK  = 8'h02;
  localparam logic [7:0] ENTRY_MASK = 8'h04;
  localparam logic [7:0] DISP_MASK  = 8'h08;
  localparam logic [7:0] DDRAM_MASK = 8'h80;
  localparam logic [7:0] SPACE      = 8'h20;

  typedef enum logic {
    SWEEP,
    IDLE
  } state_e;

  typedef enum logic [2:0] {
    CMD_CLR,
    CMD_HOME,
    CMD_ENTRY,
    CMD_DISP,
    CMD_DDRAM,
    CMD_OTHER
  } cmd_kind_e;

  // A command class matches when its mask bit is the highest bit set in the code.
  function automatic cmd_kind_e decode_cmd(input logic [7:0] code);
    cmd_kind_e kind;
    kind = CMD_OTHER;
    if (code == CLR)
      kind = CMD_CLR;
    else if ((code & DDRAM_MASK) != 8'h00)
      kind = CMD_DDRAM;
    else if ((code & ~(DISP_MASK - 8'd1)) == DISP_MASK)
      kind = CMD_DISP;
    else if ((code & ~(ENTRY_MASK - 8'd1)) == ENTRY_MASK)
      kind = CMD_ENTRY;
    else if ((code & ~(HOME_MASK - 8'd1)) == HOME_MASK)
      kind = CMD_HOME;
    return kind;
  endfunction

endpackage

// File: rtl/lcd_mon_shadow_ram.sv
// Shadow copy of the display line: one write port, one registered read-before-write port.
module lcd_mon_shadow_ram #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we)
      mem[wr_addr] <= wr_data;
    if (!rst)
      rd_data <= 8'h00;
    else
      rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/lcd_bus_monitor.sv
// HD44780-style bus responder with shadow line buffer.
// Optional BCD temperature decode enabled by defining LCD_MON_BCD_DECODE_EN.
module lcd_bus_monitor
  import lcd_mon_pkg::*;
#(
  parameter int LINE_LEN    = 16,
  parameter int FRAME_LEN   = 8,
  parameter int MIN_EN_HIGH = 1,
  localparam int AW = $clog2(LINE_LEN)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          rs,
  input  logic [7:0]    lcd_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic [AW-1:0] cursor_addr,
  output logic          disp_on,
  output logic          cursor_on,
  output logic          blink_on,
  output logic          cmd_strobe,
  output logic [7:0]    cmd_code,
  output logic          char_strobe,
  output logic          frame_done,
  output logic          busy,
  output logic          overrun,
  output logic          glitch
`ifdef LCD_MON_BCD_DECODE_EN
  ,
  output logic [15:0]   temp_bcd,
  output logic          temp_valid,
  output logic          fmt_err
`endif
);

  localparam int HW = $clog2(MIN_EN_HIGH + 1);
  localparam int CW = $clog2(FRAME_LEN + 1);
  localparam logic [HW-1:0] HI_SAT  = HW'(MIN_EN_HIGH);
  localparam logic [CW-1:0] CNT_SAT = CW'(FRAME_LEN);

  logic          en_q, en_qq, rs_q, rs_cap;
  logic [7:0]    d_q, d_cap;
  logic [HW-1:0] hi_cnt;
  state_e        state;
  logic [AW-1:0] sweep_addr;
  logic          inc_mode;
  logic [CW-1:0] char_count;

  logic          fall, accept;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_wdata;

  assign fall   = ~en_q & en_qq;
  assign accept = fall & ~busy & (hi_cnt == HI_SAT);

  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = cursor_addr;
    ram_wdata = d_cap;
    if (state == SWEEP) begin
      ram_we    = 1'b1;
      ram_addr  = sweep_addr;
      ram_wdata = SPACE;
    end else if (accept && rs_cap) begin
      ram_we = 1'b1;
    end
  end

  lcd_mon_shadow_ram #(
    .DEPTH (LINE_LEN),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we      (ram_we),
    .wr_addr (ram_addr),
    .wr_data (ram_wdata),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      en_q        <= 1'b0;
      en_qq       <= 1'b0;
      rs_q        <= 1'b0;
      d_q         <= 8'h00;
      rs_cap      <= 1'b0;
      d_cap       <= 8'h00;
      hi_cnt      <= '0;
      state       <= SWEEP;
      sweep_addr  <= '0;
      busy        <= 1'b1;
      inc_mode    <= 1'b1;
      char_count  <= '0;
      cursor_addr <= '0;
      disp_on     <= 1'b0;
      cursor_on   <= 1'b0;
      blink_on    <= 1'b0;
      cmd_strobe  <= 1'b0;
      cmd_code    <= 8'h00;
      char_strobe <= 1'b0;
      frame_done  <= 1'b0;
      overrun     <= 1'b0;
      glitch      <= 1'b0;
    end else begin
      en_q  <= en;
      en_qq <= en_q;
      rs_q  <= rs;
      d_q   <= lcd_data;
      // The capture follows the bus while en is high so the byte at the fall is kept.
      if (en_q) begin
        rs_cap <= rs_q;
        d_cap  <= d_q;
        if (hi_cnt != HI_SAT)
          hi_cnt <= hi_cnt + 1'b1;
      end else begin
        hi_cnt <= '0;
      end

      cmd_strobe  <= 1'b0;
      char_strobe <= 1'b0;
      frame_done  <= 1'b0;
      if (fall && busy)
        overrun <= 1'b1;
      if (fall && !busy && hi_cnt != HI_SAT)
        glitch <= 1'b1;

      case (state)
        SWEEP: begin
          sweep_addr <= sweep_addr + 1'b1;
          if (sweep_addr == AW'(LINE_LEN - 1)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          if (accept && !rs_cap) begin
            cmd_strobe <= 1'b1;
            cmd_code   <= d_cap;
            case (decode_cmd(d_cap))
              CMD_CLR: begin
                cursor_addr <= '0;
                char_count  <= '0;
                sweep_addr  <= '0;
                state       <= SWEEP;
                busy        <= 1'b1;
              end
              CMD_HOME:  cursor_addr <= '0;
              CMD_ENTRY: inc_mode <= d_cap[1];
              CMD_DISP:  {disp_on, cursor_on, blink_on} <= d_cap[2:0];
              CMD_DDRAM: cursor_addr <= d_cap[AW-1:0];
              default: ;
            endcase
          end else if (accept && rs_cap) begin
            char_strobe <= 1'b1;
            cursor_addr <= inc_mode ? cursor_addr + 1'b1 : cursor_addr - 1'b1;
            if (char_count != CNT_SAT) begin
              char_count <= char_count + 1'b1;
              if (char_count == CW'(FRAME_LEN - 1))
                frame_done <= 1'b1;
            end
          end
        end
      endcase
    end
  end

`ifdef LCD_MON_BCD_DECODE_EN
  logic [7:0] digit [4];
  logic [3:0] digit_bad;

  // Private mirror of the first four cells, since the RAM has only one read port.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (!rst)
        digit[i] <= SPACE;
      else if (ram_we && ram_addr == AW'(i))
        digit[i] <= ram_wdata;
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_digit_chk
    assign digit_bad[gi] = (digit[gi] < 8'h30) || (digit[gi] > 8'h39);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      temp_bcd   <= 16'h0000;
      temp_valid <= 1'b0;
      fmt_err    <= 1'b0;
    end else begin
      temp_valid <= frame_done;
      if (frame_done) begin
        temp_bcd <= {digit[3][3:0], digit[2][3:0], digit[1][3:0], digit[0][3:0]};
        if (digit_bad != 4'b0000)
          fmt_err <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_lcd_bus_monitor.sv
// Self-checking bench for lcd_bus_monitor: directed vector table plus randomized
// transactions against a transaction-level display model.
module tb_lcd_bus_monitor;

  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0, rs = 1'b0;
  logic [7:0]    lcd_data = 8'h00;
  logic [AW-1:0] rd_addr = '0;
  logic [7:0]    rd_data;
  logic [AW-1:0] cursor_addr;
  logic          disp_on, cursor_on, blink_on, cmd_strobe, char_strobe, frame_done;
  logic [7:0]    cmd_code;
  logic          busy, overrun, glitch;

  logic          en3 = 1'b0, rs3 = 1'b0;
  logic [7:0]    d3 = 8'h00;
  logic [AW-1:0] rd_addr3 = '0;
  logic [7:0]    rd_data3;
  logic [AW-1:0] cursor_addr3;
  logic          disp_on3, cursor_on3, blink_on3, cmd_strobe3, char_strobe3, frame_done3;
  logic [7:0]    cmd_code3;
  logic          busy3, overrun3, glitch3;
`ifdef LCD_MON_BCD_DECODE_EN
  logic [15:0]   temp_bcd, temp_bcd3;
  logic          temp_valid, temp_valid3, fmt_err, fmt_err3;
`endif

  always #5 clk = ~clk;

  lcd_bus_monitor u_dut (
    .clk(clk), .rst(rst), .en(en), .rs(rs), .lcd_data(lcd_data), .rd_addr(rd_addr),
    .rd_data(rd_data), .cursor_addr(cursor_addr), .disp_on(disp_on), .cursor_on(cursor_on),
    .blink_on(blink_on), .cmd_strobe(cmd_strobe), .cmd_code(cmd_code),
    .char_strobe(char_strobe), .frame_done(frame_done), .busy(busy), .overrun(overrun),
    .glitch(glitch)
`ifdef LCD_MON_BCD_DECODE_EN
    , .temp_bcd(temp_bcd), .temp_valid(temp_valid), .fmt_err(fmt_err)
`endif
  );

  lcd_bus_monitor #(.MIN_EN_HIGH(3)) u_dut3 (
    .clk(clk), .rst(rst), .en(en3), .rs(rs3), .lcd_data(d3), .rd_addr(rd_addr3),
    .rd_data(rd_data3), .cursor_addr(cursor_addr3), .disp_on(disp_on3),
    .cursor_on(cursor_on3), .blink_on(blink_on3), .cmd_strobe(cmd_strobe3),
    .cmd_code(cmd_code3), .char_strobe(char_strobe3), .frame_done(frame_done3),
    .busy(busy3), .overrun(overrun3), .glitch(glitch3)
`ifdef LCD_MON_BCD_DECODE_EN
    , .temp_bcd(temp_bcd3), .temp_valid(temp_valid3), .fmt_err(fmt_err3)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Transaction-level model of the display line.
  logic [7:0] m_mem [16];
  int         m_cur, m_cnt;
  bit         m_inc;
  logic [2:0] m_dcb;
  logic [7:0] m_code;

  task automatic model_apply(input logic r, input logic [7:0] d,
                             output int e_cmd, output int e_chr, output int e_frm,
                             output int e_busy);
    e_cmd = 0; e_chr = 0; e_frm = 0; e_busy = 0;
    if (!r) begin
      e_cmd  = 1;
      m_code = d;
      if (d == 8'h01) begin
        for (int i = 0; i < 16; i++) m_mem[i] = 8'h20;
        m_cur  = 0;
        m_cnt  = 0;
        e_busy = 16;
      end else if (d >= 8'h80) m_cur = int'(d) % 16;
      else if (d >= 8'h08 && d <= 8'h0F) m_dcb = 3'(int'(d) % 8);
      else if (d >= 8'h04 && d <= 8'h07) m_inc = ((int'(d) / 2) % 2) == 1;
      else if (d == 8'h02 || d == 8'h03) m_cur = 0;
    end else begin
      e_chr = 1;
      m_mem[m_cur] = d;
      m_cur = m_inc ? (m_cur + 1) % 16 : (m_cur + 15) % 16;
      e_frm = (m_cnt == 7) ? 1 : 0;
      if (m_cnt < 8) m_cnt++;
    end
  endtask

  int         g_off, g_tv_off;
  logic [7:0] g_rd2, g_rd3;

  // One en pulse of hi cycles, then watch strobes and wait for any sweep to finish.
  task automatic do_strobe(input logic r, input logic [7:0] d, input int hi,
                           output int ncmd, output int nchr, output int nfrm,
                           output int nbusy);
    rs = r; lcd_data = d; en = 1'b1;
    repeat (hi) @(negedge clk);
    en = 1'b0;
    ncmd = 0; nchr = 0; nfrm = 0; nbusy = 0; g_off = -1; g_tv_off = -1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (cmd_strobe) ncmd++;
      if (char_strobe) nchr++;
      if (frame_done) nfrm++;
      if (busy) nbusy++;
      if ((cmd_strobe || char_strobe) && g_off < 0) g_off = k;
      if (k == 2) g_rd2 = rd_data;
      if (k == 3) g_rd3 = rd_data;
`ifdef LCD_MON_BCD_DECODE_EN
      if (temp_valid && g_tv_off < 0) g_tv_off = k;
`endif
    end
    for (int k = 0; k < 40 && busy; k++) begin
      @(negedge clk);
      if (busy) nbusy++;
    end
    if (busy) check("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  task automatic rd(input int a, output logic [7:0] v);
    rd_addr = AW'(a);
    @(negedge clk);
    v = rd_data;
  endtask

  typedef struct {
    logic       r;
    logic [7:0] d;
    int         hi;
    int         cmd;
    int         chr;
    int         frm;
    int         bsy;
    int         cur;
    logic [2:0] dcb;
  } vec_t;

  vec_t tbl[20];

  task automatic apply_vec(input int i);
    int ncmd, nchr, nfrm, nbusy, e1, e2, e3, e4;
    do_strobe(tbl[i].r, tbl[i].d, tbl[i].hi, ncmd, nchr, nfrm, nbusy);
    model_apply(tbl[i].r, tbl[i].d, e1, e2, e3, e4);
    check($sformatf("v%0d cmd_strobe", i), ncmd, tbl[i].cmd);
    check($sformatf("v%0d char_strobe", i), nchr, tbl[i].chr);
    check($sformatf("v%0d frame_done", i), nfrm, tbl[i].frm);
    check($sformatf("v%0d busy_cycles", i), nbusy, tbl[i].bsy);
    check($sformatf("v%0d strobe_offset", i), g_off, 2);
    check($sformatf("v%0d cursor_addr", i), cursor_addr, tbl[i].cur);
    check($sformatf("v%0d dcb", i), {disp_on, cursor_on, blink_on}, tbl[i].dcb);
    if (!tbl[i].r) check($sformatf("v%0d cmd_code", i), cmd_code, tbl[i].d);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] v;
    logic [7:0] exp8 [8];
    int nb, ncmd, nchr, nfrm, nbusy, e_cmd, e_chr, e_frm, e_busy;
    logic r;
    logic [7:0] d;

    tbl[0]  = '{1'b0, 8'h0C, 2, 1, 0, 0, 0,  0, 3'b100};
    tbl[1]  = '{1'b0, 8'h01, 1, 1, 0, 0, 16, 0, 3'b100};
    tbl[2]  = '{1'b1, 8'h32, 1, 0, 1, 0, 0,  1, 3'b100};
    tbl[3]  = '{1'b1, 8'h35, 2, 0, 1, 0, 0,  2, 3'b100};
    tbl[4]  = '{1'b1, 8'h33, 1, 0, 1, 0, 0,  3, 3'b100};
    tbl[5]  = '{1'b1, 8'h30, 3, 0, 1, 0, 0,  4, 3'b100};
    tbl[6]  = '{1'b1, 8'h2E, 1, 0, 1, 0, 0,  5, 3'b100};
    tbl[7]  = '{1'b1, 8'h20, 1, 0, 1, 0, 0,  6, 3'b100};
    tbl[8]  = '{1'b1, 8'hDF, 2, 0, 1, 0, 0,  7, 3'b100};
    tbl[9]  = '{1'b1, 8'h43, 1, 0, 1, 1, 0,  8, 3'b100};
    tbl[10] = '{1'b0, 8'h8F, 1, 1, 0, 0, 0, 15, 3'b100};
    tbl[11] = '{1'b1, 8'h41, 1, 0, 1, 0, 0,  0, 3'b100};
    tbl[12] = '{1'b1, 8'h42, 2, 0, 1, 0, 0,  1, 3'b100};
    tbl[13] = '{1'b0, 8'h0F, 1, 1, 0, 0, 0,  1, 3'b111};
    tbl[14] = '{1'b0, 8'h04, 1, 1, 0, 0, 0,  1, 3'b111};
    tbl[15] = '{1'b1, 8'h78, 1, 0, 1, 0, 0,  0, 3'b111};
    tbl[16] = '{1'b1, 8'h79, 1, 0, 1, 0, 0, 15, 3'b111};
    tbl[17] = '{1'b0, 8'h06, 2, 1, 0, 0, 0, 15, 3'b111};
    tbl[18] = '{1'b0, 8'h03, 1, 1, 0, 0, 0,  0, 3'b111};
    tbl[19] = '{1'b0, 8'h38, 3, 1, 0, 0, 0,  0, 3'b111};
    exp8 = '{8'h32, 8'h35, 8'h33, 8'h30, 8'h2E, 8'h20, 8'hDF, 8'h43};

    for (int i = 0; i < 16; i++) m_mem[i] = 8'h20;
    m_cur = 0; m_cnt = 0; m_inc = 1'b1; m_dcb = 3'b000; m_code = 8'h00;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst busy", busy, 1);
    check("rst cursor", cursor_addr, 0);
    check("rst cmd_code", cmd_code, 0);
    check("rst strobes", {cmd_strobe, char_strobe, frame_done}, 0);
    check("rst flags", {disp_on, cursor_on, blink_on, overrun, glitch}, 0);
    rst = 1'b1;
    nb = 0;
    for (int k = 0; k < 40 && busy; k++) begin
      nb++;
      @(negedge clk);
    end
    check("reset sweep busy_cycles", nb, 16);
    for (int a = 0; a < 16; a++) begin
      rd(a, v);
      check($sformatf("reset shadow[%0d]", a), v, 8'h20);
    end
    check("post-reset disp_on", disp_on, 0);

    // Directed table: display on, clear, one frame of text
    for (int i = 0; i <= 9; i++) apply_vec(i);
    for (int a = 0; a < 8; a++) begin
      rd(a, v);
      check($sformatf("frame shadow[%0d]", a), v, exp8[a]);
    end
`ifdef LCD_MON_BCD_DECODE_EN
    check("temp_valid offset", g_tv_off, 3);
    check("temp_bcd", temp_bcd, 16'h0352);
    check("fmt_err", fmt_err, 0);
`endif

    // DDRAM jump and wrap; read-before-write on the written cell
    apply_vec(10);
    rd_addr = 4'd15;
    apply_vec(11);
    check("rbw old value", g_rd2, 8'h20);
    check("rbw new value", g_rd3, 8'h41);
    apply_vec(12);
    rd(15, v); check("wrap shadow[15]", v, 8'h41);
    rd(0, v);  check("wrap shadow[0]", v, 8'h42);
    for (int i = 13; i <= 19; i++) apply_vec(i);
    rd(1, v);  check("dec shadow[1]", v, 8'h78);
    rd(0, v);  check("dec shadow[0]", v, 8'h79);

    // Strobe during the clear sweep is an overrun and is dropped
    rs = 1'b0; lcd_data = 8'h01; en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    model_apply(1'b0, 8'h01, e_cmd, e_chr, e_frm, e_busy);
    repeat (5) @(negedge clk);
    rs = 1'b1; lcd_data = 8'h5A; en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    nchr = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (char_strobe) nchr++;
    end
    check("overrun char_strobe", nchr, 0);
    check("overrun flag", overrun, 1);
    for (int k = 0; k < 40 && busy; k++) @(negedge clk);
    check("overrun sweep finished", busy, 0);
    for (int a = 0; a < 16; a++) begin
      rd(a, v);
      check($sformatf("overrun shadow[%0d]", a), v, 8'h20);
    end
    check("overrun cursor", cursor_addr, 0);

    // Randomized transactions against the model
    for (int n = 0; n < 150; n++) begin
      r = 1'($urandom_range(0, 1));
      d = 8'($urandom);
      if ($urandom_range(0, 15) == 0) begin
        r = 1'b0;
        d = 8'h01;
      end
      do_strobe(r, d, int'($urandom_range(1, 3)), ncmd, nchr, nfrm, nbusy);
      model_apply(r, d, e_cmd, e_chr, e_frm, e_busy);
      check($sformatf("rnd%0d cmd_strobe", n), ncmd, e_cmd);
      check($sformatf("rnd%0d char_strobe", n), nchr, e_chr);
      check($sformatf("rnd%0d frame_done", n), nfrm, e_frm);
      check($sformatf("rnd%0d busy_cycles", n), nbusy, e_busy);
      check($sformatf("rnd%0d cursor", n), cursor_addr, m_cur);
      check($sformatf("rnd%0d dcb", n), {disp_on, cursor_on, blink_on}, m_dcb);
      check($sformatf("rnd%0d cmd_code", n), cmd_code, m_code);
      if (n % 30 == 29) begin
        for (int a = 0; a < 16; a++) begin
          rd(a, v);
          check($sformatf("rnd%0d shadow[%0d]", n, a), v, m_mem[a]);
        end
      end
    end
    check("glitch stays clear", glitch, 0);
    check("overrun sticky", overrun, 1);

    // Short en pulse on the MIN_EN_HIGH=3 instance is a glitch; a 3-cycle one is accepted
    for (int k = 0; k < 40 && busy3; k++) @(negedge clk);
    check("dut3 idle", busy3, 0);
    check("dut3 glitch before", glitch3, 0);
    rs3 = 1'b0; d3 = 8'h0C; en3 = 1'b1;
    @(negedge clk);
    en3 = 1'b0;
    ncmd = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (cmd_strobe3) ncmd++;
    end
    check("dut3 short cmd_strobe", ncmd, 0);
    check("dut3 glitch", glitch3, 1);
    check("dut3 short disp_on", disp_on3, 0);
    en3 = 1'b1;
    repeat (3) @(negedge clk);
    en3 = 1'b0;
    ncmd = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (cmd_strobe3) ncmd++;
    end
    check("dut3 long cmd_strobe", ncmd, 1);
    check("dut3 long disp_on", disp_on3, 1);
    check("dut3 cmd_code", cmd_code3, 8'h0C);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
